// File: rtl/noc_link_pkg.sv
// ============================================================================
//  Package     : noc_link_pkg
//  Description : Shared constants, helper function and link type for the
//                credit-based NoC link (transmitter and receiver sides).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_link_pkg;

   // Receiver buffer depth shared by the transmitter credit pool and the
   // receiver-side FIFO.
   localparam int DEFAULT_CREDITS    = 4;
   localparam int DEFAULT_DATA_WIDTH = 16;

   // Width needed to hold a credit count in the range 0..depth.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Link bundle at the default flit width; modules with another width
   // declare the same shape locally from their DATA_WIDTH.
   typedef struct packed {
      logic                          valid;
      logic [DEFAULT_DATA_WIDTH-1:0] data;
   } link_default_t;

endpackage : noc_link_pkg

`default_nettype wire

// File: rtl/fifo_credit_tx_credit_counter.sv
// ============================================================================
//  Module      : credit_counter
//  Description : Up/down counter that resets to MAX_VAL and saturates at
//                0 and MAX_VAL. Simultaneous inc and dec leave it unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_counter #(
   parameter int MAX_VAL = 4,
   parameter int CNT_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             zero,
   output logic             full
);

   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_VAL);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: a lone inc or dec moves by one, clamped to the legal range.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec) begin
         if (cnt_q != C_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register, starts with the whole credit pool available.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= C_MAX;
      else        cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);
   assign full = (cnt_q == C_MAX);

endmodule : credit_counter

`default_nettype wire

// File: rtl/fifo_credit_tx.sv
// ============================================================================
//  Module      : fifo_credit_tx
//  Description : Credit-based link transmitter. Pops the upstream FIFO only
//                while the receiver has a free slot and drives a registered
//                valid/data link. Returned credits are usable one cycle later.
//  Options     : FIFO_CREDIT_TX_STALL_CNT_EN adds a 32-bit saturating count of
//                cycles stalled with data waiting and no credits (stall_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_credit_tx
   import noc_link_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int CREDITS    = DEFAULT_CREDITS,
   localparam int CNT_W      = credit_width(CREDITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_valid,
   output logic                  fifo_pop,
   output logic [DATA_WIDTH-1:0] link_data,
   output logic                  link_valid,
   input  logic                  credit_in,
   output logic                  credits_full,
`ifdef FIFO_CREDIT_TX_STALL_CNT_EN
   output logic [31:0]           stall_cnt,
`endif
   output logic [CNT_W-1:0]      credit_cnt
);

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
   } link_t;

   link_t link_q;
   link_t link_d;
   logic  cnt_zero;

   credit_counter #(
      .MAX_VAL (CREDITS),
      .CNT_W   (CNT_W)
   ) u_credit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .dec   (fifo_pop),
      .inc   (credit_in),
      .cnt   (credit_cnt),
      .zero  (cnt_zero),
      .full  (credits_full)
   );

   // Pop depends only on the registered credit count, never on credit_in.
   assign fifo_pop = fifo_valid & ~cnt_zero;

   // Next link state: one-cycle valid per popped flit, data held otherwise.
   always_comb begin
      link_d.valid = fifo_pop;
      link_d.data  = fifo_pop ? fifo_data : link_q.data;
   end

   // Link register; only valid is cleared by reset, data is don't-care then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) link_q.valid <= 1'b0;
      else        link_q       <= link_d;
   end

   assign link_valid = link_q.valid;
   assign link_data  = link_q.data;

`ifdef FIFO_CREDIT_TX_STALL_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] stall_d;

   // Count cycles with a flit waiting but no credit, saturating at all-ones.
   always_comb begin
      stall_d = stall_q;
      if (fifo_valid && cnt_zero && (stall_q != 32'hFFFF_FFFF))
         stall_d = stall_q + 32'd1;
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= 32'd0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

`ifndef SYNTHESIS
   // Protocol and sanity checks sampled on each active edge out of reset.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!$isunknown(fifo_valid)) else $fatal(1, "fifo_valid is X");
         assert (!$isunknown(credit_in))  else $fatal(1, "credit_in is X");
         assert (!fifo_pop || fifo_valid) else $fatal(1, "pop without valid");
         assert (credit_cnt <= CNT_W'(CREDITS))
            else $fatal(1, "credit count above pool size");
         assert (!(credit_in && credits_full && !fifo_pop))
            else $fatal(1, "credit returned while pool already full");
      end
   end
`endif

endmodule : fifo_credit_tx

`default_nettype wire

// File: tb/tb_fifo_credit_tx.sv
// ============================================================================
//  Module      : tb_fifo_credit_tx
//  Description : Directed self-checking bench for fifo_credit_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_credit_tx;

   localparam int DW = 16;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] fifo_data;
   logic          fifo_valid;
   logic          fifo_pop;
   logic [DW-1:0] link_data;
   logic          link_valid;
   logic          credit_in;
   logic          credits_full;
   logic [2:0]    credit_cnt;
`ifdef FIFO_CREDIT_TX_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   fifo_credit_tx #(
      .DATA_WIDTH (DW),
      .CREDITS    (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_data    (fifo_data),
      .fifo_valid   (fifo_valid),
      .fifo_pop     (fifo_pop),
      .link_data    (link_data),
      .link_valid   (link_valid),
      .credit_in    (credit_in),
      .credits_full (credits_full),
`ifdef FIFO_CREDIT_TX_STALL_CNT_EN
      .stall_cnt    (stall_cnt),
`endif
      .credit_cnt   (credit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full status check of the outputs: pop, count, full, link valid/data.
   task automatic chk_all(input string tag, input logic ep, input logic [2:0] ec,
                          input logic ef, input logic ev, input logic [DW-1:0] ed);
      chk({tag, ".pop"},  32'(fifo_pop),     32'(ep));
      chk({tag, ".cnt"},  32'(credit_cnt),   32'(ec));
      chk({tag, ".full"}, 32'(credits_full), 32'(ef));
      chk({tag, ".lv"},   32'(link_valid),   32'(ev));
      chk({tag, ".ld"},   32'(link_data),    32'(ed));
   endtask

   // Apply inputs just after a rising edge, then wait to the sampling edge.
   task automatic drive(input logic fv, input logic ci, input logic [DW-1:0] d);
      fifo_valid = fv;
      credit_in  = ci;
      fifo_data  = d;
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b1;
      fifo_valid = 1'b0;
      credit_in  = 1'b0;
      fifo_data  = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst.cnt",  32'(credit_cnt),   32'd4);
      chk("rst.lv",   32'(link_valid),   32'd0);
      chk("rst.full", 32'(credits_full), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Burst of four flits drains all credits.
      drive(1, 0, 16'h0001); chk("a0.pop", 32'(fifo_pop), 32'd1);
      chk("a0.cnt", 32'(credit_cnt), 32'd4); chk("a0.lv", 32'(link_valid), 32'd0);
      next_cycle();
      drive(1, 0, 16'h0002); chk_all("a1", 1, 3'd3, 0, 1, 16'h0001); next_cycle();
      drive(1, 0, 16'h0003); chk_all("a2", 1, 3'd2, 0, 1, 16'h0002); next_cycle();
      drive(1, 0, 16'h0004); chk_all("a3", 1, 3'd1, 0, 1, 16'h0003); next_cycle();
      drive(1, 0, 16'h0005); chk_all("a4", 0, 3'd0, 0, 1, 16'h0004); next_cycle();

      // Single credit return: no pop in the credit cycle, one pop after.
      drive(1, 1, 16'h0005); chk_all("b0", 0, 3'd0, 0, 0, 16'h0004); next_cycle();
      drive(1, 0, 16'h0005); chk_all("b1", 1, 3'd1, 0, 0, 16'h0004); next_cycle();
      drive(1, 0, 16'h0006); chk_all("b2", 0, 3'd0, 0, 1, 16'h0005); next_cycle();

      // Refill to two credits with the FIFO empty.
      drive(0, 1, 16'h0006); chk_all("c0", 0, 3'd0, 0, 0, 16'h0005); next_cycle();
      drive(0, 1, 16'h0006); chk_all("c1", 0, 3'd1, 0, 0, 16'h0005); next_cycle();

      // Pop and credit return together for ten cycles: count stays at two.
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 16'h0100 + 16'(i));
         chk("s.pop", 32'(fifo_pop),   32'd1);
         chk("s.cnt", 32'(credit_cnt), 32'd2);
         if (i > 0) begin
            chk("s.lv", 32'(link_valid), 32'd1);
            chk("s.ld", 32'(link_data),  32'(16'h0100 + 16'(i - 1)));
         end
         next_cycle();
      end
      drive(0, 0, 16'h0000); chk_all("s.end", 0, 3'd2, 0, 1, 16'h0109); next_cycle();

      // Spend the last two credits, then return four with the FIFO empty.
      drive(1, 0, 16'h0200); chk_all("d0", 1, 3'd2, 0, 0, 16'h0109); next_cycle();
      drive(1, 0, 16'h0201); chk_all("d1", 1, 3'd1, 0, 1, 16'h0200); next_cycle();
      drive(0, 1, 16'h0202); chk_all("d2", 0, 3'd0, 0, 1, 16'h0201); next_cycle();
      drive(0, 1, 16'h0202); chk_all("d3", 0, 3'd1, 0, 0, 16'h0201); next_cycle();
      drive(0, 1, 16'h0202); chk_all("d4", 0, 3'd2, 0, 0, 16'h0201); next_cycle();
      drive(0, 1, 16'h0202); chk_all("d5", 0, 3'd3, 0, 0, 16'h0201); next_cycle();
      drive(0, 0, 16'h0202); chk_all("d6", 0, 3'd4, 1, 0, 16'h0201); next_cycle();

      // Three sends leave one credit with a flit in flight, then reset mid-cycle.
      drive(1, 0, 16'h0300); next_cycle();
      drive(1, 0, 16'h0301); next_cycle();
      drive(1, 0, 16'h0302); next_cycle();
      fifo_valid = 1'b0;
      #1;
      chk("e.pre.lv",  32'(link_valid), 32'd1);
      chk("e.pre.cnt", 32'(credit_cnt), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("e.lv",   32'(link_valid),   32'd0);
      chk("e.cnt",  32'(credit_cnt),   32'd4);
      chk("e.full", 32'(credits_full), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Exhaust credits, then stall for twenty cycles.
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 16'h0400 + 16'(i));
         chk("f.pop", 32'(fifo_pop), 32'd1);
         next_cycle();
      end
`ifdef FIFO_CREDIT_TX_STALL_CNT_EN
      chk("f.stall0", stall_cnt, 32'd0);
`endif
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 16'h0404);
         chk("f.nopop", 32'(fifo_pop), 32'd0);
         next_cycle();
      end
      chk("f.cnt", 32'(credit_cnt), 32'd0);
`ifdef FIFO_CREDIT_TX_STALL_CNT_EN
      chk("f.stall20", stall_cnt, 32'd20);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fifo_credit_tx

`default_nettype wire
